gcd_req_scheduler: RTL and testbench
====================================

Name: gcd_req_scheduler

Overview:
- Shares one subtractive GCD engine among N_REQ requesters using round-robin arbitration.
- Accepts operand pairs through a valid/ready handshake and sequences the engine with a start pulse.
- Watches for the engine's done pulse, with a timeout watchdog, and returns the result or an error to the granted requester.
- Sits between the requester ports and the single shared engine instance.

Parameters:
- N_REQ, 4, number of requesters (legal 2..8)
- W, 8, operand/result width in bits
- TIMEOUT, 1023, max WAIT cycles before abort (legal 1..65535)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  N_REQ  per-requester operand valid
- req_a  input  N_REQ*W  operand a; requester i occupies bits [i*W +: W]
- req_b  input  N_REQ*W  operand b; same packing as req_a
- req_ready  output  N_REQ  one-hot accept; at most one bit high
- resp_valid  output  N_REQ  one-hot result strobe, one cycle, no backpressure
- resp_result  output  W  result, valid while resp_valid is nonzero
- resp_err  output  1  timeout flag, qualified by resp_valid
- eng_start  output  1  one-cycle engine start pulse
- eng_a  output  W  engine operand a, held from ISSUE to the end of WAIT
- eng_b  output  W  engine operand b, same hold as eng_a
- eng_clr  output  1  one-cycle engine abort pulse on timeout
- eng_done  input  1  engine completion pulse
- eng_result  input  W  engine result, sampled when eng_done=1
- busy  output  1  high in any state other than IDLE
- grant_id  output  $clog2(N_REQ)  index of the current or last granted requester

Behaviour:
- Reset: rst asynchronous, active-high; clock clk.
  - State goes to IDLE and the round-robin pointer last_grant goes to N_REQ-1, so the first grant is requester 0.
  - All outputs reset to 0: req_ready, resp_valid, resp_result, resp_err, eng_start, eng_a, eng_b, eng_clr, busy, grant_id.
  - Reset mid-operation discards the job with no response. The engine must be reset by the same rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching last_grant+1, last_grant+2, ... modulo N_REQ.
  - req_ready is combinational: asserted only in IDLE, only for the winner. Handshake completes when req_valid[i] & req_ready[i] at a rising edge.
  - On handshake: latch req_a/req_b slices into eng_a/eng_b, set grant_id=i, go to ISSUE.
  - No request pending: stay in IDLE.
  - A requester may drop req_valid before it is granted; it then loses nothing.
- ISSUE: eng_start=1 for exactly this cycle; clear timer to 0; go to WAIT.
- WAIT:
  - Timer (16-bit) increments each cycle.
  - eng_done=1: capture eng_result, resp_err=0, go to RESP.
  - Otherwise, when timer==TIMEOUT-1: resp_err=1, resp_result=0, eng_clr=1 for one cycle, go to RESP.
  - eng_done and timeout in the same cycle: done wins.
- RESP:
  - resp_valid[grant_id]=1 for exactly one cycle, with resp_result and resp_err stable during it.
  - last_grant <= grant_id; go to IDLE.
- eng_done outside WAIT is ignored.
- Latency, handshake at edge T:
  - eng_start high in cycle T+1.
  - If eng_done is sampled at the edge ending WAIT cycle k, resp_valid is high in cycle k+1.
  - Earliest next acceptance is in the cycle after RESP.
- Fairness: a continuously asserting requester waits at most N_REQ-1 jobs.
- Zero operands are passed to the engine unchanged unless the optional bypass feature is compiled in.

Optional Feature:
- Macro: GCD_ZERO_BYPASS_EN.
- Defined: in IDLE, a handshake whose a==0 or b==0 goes directly to RESP.
  - resp_result = (a==0) ? b : a; resp_err=0.
  - No eng_start, no WAIT; response in the cycle after acceptance.
  - last_grant still updates.
- Undefined: every accepted job goes through ISSUE/WAIT. Zero operands are sent to the engine unchanged.

Test Plan:
- Single job: req_valid=0001, a=48, b=18; engine model returns 6 after 5 cycles -> req_ready=0001 for one cycle, eng_start one cycle later with eng_a=48/eng_b=18, resp_valid=0001, resp_result=6, resp_err=0.
- Round-robin: all 4 requesters hold req_valid with distinct pairs (12,8)(9,6)(35,14)(17,5) -> grants in order 0,1,2,3,0; results 4,3,7,1 routed to the matching one-hot resp_valid.
- Timeout: TIMEOUT=20, engine never asserts done -> 20 WAIT cycles, then eng_clr pulse, resp_valid to the requester with resp_err=1, resp_result=0; next request is served normally.
- Simultaneous done and timeout in the same cycle -> resp_err=0, resp_result=eng_result.
- Reset mid-WAIT: rst asserted 3 cycles after eng_start -> all outputs 0 immediately; no resp_valid follows; the next request goes to requester 0 first.
- With GCD_ZERO_BYPASS_EN, a=0, b=25 -> no eng_start; resp_valid one cycle after acceptance with result 25. Without the macro, eng_start is issued with eng_a=0, eng_b=25.

Source files
------------

// File: rtl/gcd_req_scheduler.sv
// Round-robin scheduler that shares one GCD engine among N_REQ requesters, with a WAIT watchdog.
// Optional build macro GCD_ZERO_BYPASS_EN answers jobs with a zero operand without using the engine.
module gcd_req_scheduler #(
   parameter int N_REQ   = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*W-1:0]         req_a,
   input  logic [N_REQ*W-1:0]         req_b,
   output logic [N_REQ-1:0]           req_ready,
   output logic [N_REQ-1:0]           resp_valid,
   output logic [W-1:0]               resp_result,
   output logic                       resp_err,
   output logic                       eng_start,
   output logic [W-1:0]               eng_a,
   output logic [W-1:0]               eng_b,
   output logic                       eng_clr,
   input  logic                       eng_done,
   input  logic [W-1:0]               eng_result,
   output logic                       busy,
   output logic [$clog2(N_REQ)-1:0]   grant_id
);

   localparam int GW = $clog2(N_REQ);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [GW-1:0]   last_grant_r;
   logic [GW-1:0]   grant_id_r;
   logic [GW-1:0]   win_idx_s;
   logic [GW-1:0]   cand_s;
   logic            win_found_s;
   logic            hs_s;
   logic            zero_job_s;
   logic            timeout_s;
   logic [W-1:0]    win_a_s;
   logic [W-1:0]    win_b_s;
   logic [15:0]     timer_r;
   logic [N_REQ-1:0] resp_valid_r;
   logic [W-1:0]    resp_result_r;
   logic            resp_err_r;
   logic            eng_start_r;
   logic            eng_clr_r;
   logic [W-1:0]    eng_a_r;
   logic [W-1:0]    eng_b_r;
   logic            busy_r;

   function automatic logic [N_REQ-1:0] onehot(input logic [GW-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin search starting just after the last granted requester
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_s      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand_s = GW'((int'(last_grant_r) + k) % N_REQ);
         if (!win_found_s && req_valid[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   assign win_a_s   = req_a[int'(win_idx_s)*W +: W];
   assign win_b_s   = req_b[int'(win_idx_s)*W +: W];
   assign hs_s      = (state_r == ST_IDLE) && win_found_s;
   assign timeout_s = (timer_r == 16'(TIMEOUT - 1));
   assign req_ready = hs_s ? onehot(win_idx_s) : {N_REQ{1'b0}};

`ifdef GCD_ZERO_BYPASS_EN
   assign zero_job_s = (win_a_s == {W{1'b0}}) || (win_b_s == {W{1'b0}});
`else
   assign zero_job_s = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; done takes priority over the watchdog
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (hs_s) begin
               state_nxt_s = zero_job_s ? ST_RESP : ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: state_nxt_s = ST_WAIT;
         ST_WAIT: begin
            if (eng_done || timeout_s) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_RESP: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs; strobes default low every cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_r  <= GW'(N_REQ - 1);
         grant_id_r    <= '0;
         timer_r       <= 16'd0;
         resp_valid_r  <= '0;
         resp_result_r <= '0;
         resp_err_r    <= 1'b0;
         eng_start_r   <= 1'b0;
         eng_clr_r     <= 1'b0;
         eng_a_r       <= '0;
         eng_b_r       <= '0;
         busy_r        <= 1'b0;
      end else begin
         eng_start_r  <= 1'b0;
         eng_clr_r    <= 1'b0;
         resp_valid_r <= '0;
         busy_r       <= (state_nxt_s != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (hs_s) begin
                  eng_a_r    <= win_a_s;
                  eng_b_r    <= win_b_s;
                  grant_id_r <= win_idx_s;
                  if (zero_job_s) begin
                     resp_valid_r  <= onehot(win_idx_s);
                     resp_result_r <= (win_a_s == {W{1'b0}}) ? win_b_s : win_a_s;
                     resp_err_r    <= 1'b0;
                  end else begin
                     eng_start_r <= 1'b1;
                  end
               end else begin
                  eng_start_r <= 1'b0;
               end
            end
            ST_ISSUE: timer_r <= 16'd0;
            ST_WAIT: begin
               timer_r <= timer_r + 16'd1;
               if (eng_done) begin
                  resp_valid_r  <= onehot(grant_id_r);
                  resp_result_r <= eng_result;
                  resp_err_r    <= 1'b0;
               end else if (timeout_s) begin
                  resp_valid_r  <= onehot(grant_id_r);
                  resp_result_r <= '0;
                  resp_err_r    <= 1'b1;
                  eng_clr_r     <= 1'b1;
               end else begin
                  resp_valid_r <= '0;
               end
            end
            ST_RESP: last_grant_r <= grant_id_r;
            default: resp_valid_r <= '0;
         endcase
      end
   end

   assign resp_valid  = resp_valid_r;
   assign resp_result = resp_result_r;
   assign resp_err    = resp_err_r;
   assign eng_start   = eng_start_r;
   assign eng_clr     = eng_clr_r;
   assign eng_a       = eng_a_r;
   assign eng_b       = eng_b_r;
   assign busy        = busy_r;
   assign grant_id    = grant_id_r;

endmodule

// File: tb/tb_gcd_req_scheduler.sv
// Directed table-driven bench for gcd_req_scheduler with a behavioural latency-programmable GCD engine.
// Zero-operand expectations follow GCD_ZERO_BYPASS_EN when it is defined for the build.
module tb_gcd_req_scheduler;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int TO = 20;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   resp_valid;
   logic [W-1:0]   resp_result;
   logic           resp_err;
   logic           eng_start;
   logic [W-1:0]   eng_a;
   logic [W-1:0]   eng_b;
   logic           eng_clr;
   logic           eng_done;
   logic [W-1:0]   eng_result;
   logic           busy;
   logic [1:0]     grant_id;

   int n_cmp = 0;
   int n_bad = 0;

   gcd_req_scheduler #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_result(resp_result),
      .resp_err(resp_err), .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
      .eng_clr(eng_clr), .eng_done(eng_done), .eng_result(eng_result),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x, y, t;
      x = a;
      y = b;
      for (int i = 0; i < 300 && y != 0; i++) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Engine model: done pulses in the eng_lat-th cycle after the start edge
   int           eng_lat = 1;
   int           eng_cnt;
   logic         eng_busy;
   logic [W-1:0] eng_res;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_busy <= 1'b0;
         eng_cnt  <= 0;
         eng_res  <= '0;
      end else if (eng_clr) begin
         eng_busy <= 1'b0;
      end else if (eng_start) begin
         eng_busy <= 1'b1;
         eng_cnt  <= eng_lat - 1;
         eng_res  <= gcd_ref(eng_a, eng_b);
      end else if (eng_busy) begin
         if (eng_cnt == 0) eng_busy <= 1'b0;
         else eng_cnt <= eng_cnt - 1;
      end
   end
   assign eng_done   = eng_busy && (eng_cnt == 0);
   assign eng_result = eng_done ? eng_res : '0;

   typedef struct {
      logic [N-1:0]   rv;
      logic [N*W-1:0] a_bus;
      logic [N*W-1:0] b_bus;
      int             grant;
      logic [W-1:0]   result;
      logic           err;
      int             lat;
      int             steps;
      logic           clr;
      logic           bypass;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(input logic [N-1:0] rv, input logic [N*W-1:0] a_bus,
                               input logic [N*W-1:0] b_bus, input int grant,
                               input logic [W-1:0] result, input logic err,
                               input int lat, input logic bypass);
      vec_t v;
      v.rv     = rv;
      v.a_bus  = a_bus;
      v.b_bus  = b_bus;
      v.grant  = grant;
      v.result = result;
      v.err    = err;
      v.lat    = lat;
      v.steps  = (lat > TO) ? TO + 1 : lat + 1;
      v.clr    = (lat > TO);
      v.bypass = bypass;
      return v;
   endfunction

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run_job(input vec_t v);
      int n;
      logic [W-1:0] ea, eb;
      ea = v.a_bus[v.grant*W +: W];
      eb = v.b_bus[v.grant*W +: W];
      req_valid = v.rv;
      req_a     = v.a_bus;
      req_b     = v.b_bus;
      eng_lat   = v.lat;
      n = 0;
      #1;
      while (req_ready == '0 && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      chk("grant_ready", 32'(req_ready), 32'(oh(v.grant)));
      chk("idle_resp_quiet", 32'(resp_valid), 32'd0);
      @(negedge clk); #1;
      chk("grant_id", 32'(grant_id), 32'(v.grant));
      chk("busy", 32'(busy), 32'd1);
      if (v.bypass) begin
         chk("byp_no_start", 32'(eng_start), 32'd0);
         chk("byp_resp_valid", 32'(resp_valid), 32'(oh(v.grant)));
         chk("byp_result", 32'(resp_result), 32'(v.result));
         chk("byp_err", 32'(resp_err), 32'd0);
      end else begin
         chk("eng_start", 32'(eng_start), 32'd1);
         chk("eng_a", 32'(eng_a), 32'(ea));
         chk("eng_b", 32'(eng_b), 32'(eb));
         n = 0;
         do begin
            @(negedge clk); #1;
            n++;
            if (n == 1) chk("start_one_cycle", 32'(eng_start), 32'd0);
         end while (resp_valid == '0 && n < 200);
         chk("resp_latency", 32'(n), 32'(v.steps));
         chk("resp_valid", 32'(resp_valid), 32'(oh(v.grant)));
         chk("resp_result", 32'(resp_result), 32'(v.result));
         chk("resp_err", 32'(resp_err), 32'(v.err));
         chk("eng_clr", 32'(eng_clr), 32'(v.clr));
         chk("eng_hold_a", 32'(eng_a), 32'(ea));
      end
   endtask

   logic [N*W-1:0] rr_a, rr_b;
   logic           zbyp;
   logic [N-1:0]   seen_resp;
   logic           seen_start;
   int             n;

   initial begin
      rr_a = {8'd17, 8'd35, 8'd9, 8'd12};
      rr_b = {8'd5, 8'd14, 8'd6, 8'd8};
`ifdef GCD_ZERO_BYPASS_EN
      zbyp = 1'b1;
`else
      zbyp = 1'b0;
`endif
      vecs[0] = mk(4'b1111, rr_a, rr_b, 0, 8'd4, 1'b0, 3, 1'b0);
      vecs[1] = mk(4'b1111, rr_a, rr_b, 1, 8'd3, 1'b0, 5, 1'b0);
      vecs[2] = mk(4'b1111, rr_a, rr_b, 2, 8'd7, 1'b0, 1, 1'b0);
      vecs[3] = mk(4'b1111, rr_a, rr_b, 3, 8'd1, 1'b0, 2, 1'b0);
      vecs[4] = mk(4'b1111, rr_a, rr_b, 0, 8'd4, 1'b0, 4, 1'b0);
      vecs[5] = mk(4'b0001, {24'd0, 8'd48}, {24'd0, 8'd18}, 0, 8'd6, 1'b0, 5, 1'b0);
      vecs[6] = mk(4'b0100, {8'd0, 8'd0, 16'd0}, {8'd0, 8'd25, 16'd0}, 2, 8'd25, 1'b0, 3, zbyp);
      vecs[7] = mk(4'b0010, {16'd0, 8'd21, 8'd0}, {16'd0, 8'd14, 8'd0}, 1, 8'd0, 1'b1, 1000, 1'b0);
      vecs[8] = mk(4'b0010, {16'd0, 8'd21, 8'd0}, {16'd0, 8'd14, 8'd0}, 1, 8'd7, 1'b0, 2, 1'b0);
      vecs[9] = mk(4'b0010, {16'd0, 8'd30, 8'd0}, {16'd0, 8'd45, 8'd0}, 1, 8'd15, 1'b0, TO, 1'b0);

      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_eng_start", 32'(eng_start), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_job(vecs[i]);

      // Reset three cycles into the engine run: job vanishes, pointer restarts at 0
      req_valid = 4'b0100;
      req_a     = {8'd0, 8'd48, 16'd0};
      req_b     = {8'd0, 8'd18, 16'd0};
      eng_lat   = 50;
      n = 0;
      #1;
      while (req_ready == '0 && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      chk("mid_grant", 32'(req_ready), 32'b0100);
      @(negedge clk); #1;
      chk("mid_start", 32'(eng_start), 32'd1);
      repeat (3) @(negedge clk);
      req_valid = '0;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_grant", 32'(grant_id), 32'd0);
      chk("mid_rst_eng_a", 32'(eng_a), 32'd0);
      chk("mid_rst_eng_b", 32'(eng_b), 32'd0);
      chk("mid_rst_resp", 32'({resp_valid, resp_result, resp_err, eng_clr, eng_start}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen_resp  = '0;
      seen_start = 1'b0;
      repeat (30) begin
         @(negedge clk); #1;
         seen_resp  = seen_resp | resp_valid;
         seen_start = seen_start | eng_start;
      end
      chk("no_resp_after_rst", 32'(seen_resp), 32'd0);
      chk("no_start_after_rst", 32'(seen_start), 32'd0);
      req_valid = 4'b1111;
      req_a     = rr_a;
      req_b     = rr_b;
      #1;
      chk("first_grant_after_rst", 32'(req_ready), 32'b0001);
      @(negedge clk);
      req_valid = '0;
      repeat (40) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
